rgbw_frame_decoder: RTL and testbench

Consumes the byte stream from the SPI slave stage (`rdy` + `data[7:0]`) and assembles framed write commands into four 8-bit colour intensity registers for the downstream RGBW PWM stage. A frame is one header byte followed by four channel bytes (R, G, B, W). All four channels update atomically at frame end, gated per channel by a mask in the header. Chip-select deassertion aborts any partial frame.

---
 rtl/rgbw_frame_decoder.sv | 129 ++++++++++++
 tb/tb_rgbw_frame_decoder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/rgbw_frame_decoder.sv
// rgbw_frame_decoder
//   Assembles framed write commands from the SPI slave byte stream into four
//   8-bit colour registers (R, G, B, W) for the downstream PWM stage.
//   Frame: header {HDR_TAG, mask[3:0]} then R, G, B, W bytes. All enabled
//   channels commit together at frame end. The mask bits are bit3=R,
//   bit2=G, bit1=B and bit0=W.
//   Optional macro RGBW_FRAME_CHECKSUM_EN adds a sixth byte. That byte must
//   equal header^R^G^B^W, or the frame is rejected.
// Ports:
//   clk        system clock (shared with SPI slave)
//   reset      async active-low reset
//   cs         SPI chip select, active-low; high aborts/realigns framing
//   rdy, data  byte-ready level and received byte
//   red/green/blue/white  committed intensities (registered)
//   update     1-cycle pulse with newly committed values
//   frame_err  1-cycle pulse on rejected or aborted frame
module rgbw_frame_decoder #(
  parameter logic [3:0] HDR_TAG = 4'hA
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       rdy,
  input  logic [7:0] data,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic [7:0] white,
  output logic       update,
  output logic       frame_err
);

  typedef enum logic [1:0] {HDR = 2'd0, DATA = 2'd1, IGNORE = 2'd2, CHK = 2'd3} state_t;

  state_t          state, state_n;
  logic            rdy_prev;
  logic [1:0]      idx, idx_n;
  logic [3:0]      mask, mask_n;
  logic [3:0][7:0] shadow, sh_n;
  logic            accept, commit, err;

  // rdy may stay high for several cycles; only its rising edge is a byte.
  assign accept = rdy & ~rdy_prev;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    mask_n  = mask;
    sh_n    = shadow;
    commit  = 1'b0;
    err     = 1'b0;
    if (cs) begin
      // Deselect realigns framing and drops any byte arriving this cycle.
      state_n = HDR;
      idx_n   = 2'd0;
      mask_n  = 4'd0;
      err     = (state == DATA) || (state == CHK);
    end else if (accept) begin
      case (state)
        HDR: begin
          if (data[7:4] == HDR_TAG) begin
            mask_n  = data[3:0];
            idx_n   = 2'd0;
            state_n = DATA;
          end else begin
            err     = 1'b1;
            state_n = IGNORE;
          end
        end
        DATA: begin
          sh_n[idx] = data;
          idx_n     = idx + 2'd1;
          if (idx == 2'd3) begin
`ifdef RGBW_FRAME_CHECKSUM_EN
            state_n = CHK;
`else
            commit  = 1'b1;
            state_n = HDR;
`endif
          end
        end
`ifdef RGBW_FRAME_CHECKSUM_EN
        CHK: begin
          if (data == ({HDR_TAG, mask} ^ shadow[0] ^ shadow[1] ^ shadow[2] ^ shadow[3]))
            commit = 1'b1;
          else
            err = 1'b1;
          state_n = HDR;
        end
`endif
        IGNORE: state_n = IGNORE;
        default: state_n = HDR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= HDR;
      rdy_prev  <= 1'b0;
      idx       <= 2'd0;
      mask      <= 4'd0;
      shadow    <= '0;
      red       <= 8'h00;
      green     <= 8'h00;
      blue      <= 8'h00;
      white     <= 8'h00;
      update    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      rdy_prev  <= rdy;
      idx       <= idx_n;
      mask      <= mask_n;
      shadow    <= sh_n;
      update    <= commit;
      frame_err <= err;
      // sh_n is used so the W byte that arrives in the commit cycle is
      // included when no checksum stage exists.
      if (commit) begin
        if (mask[3]) red   <= sh_n[0];
        if (mask[2]) green <= sh_n[1];
        if (mask[1]) blue  <= sh_n[2];
        if (mask[0]) white <= sh_n[3];
      end
    end
  end

endmodule

// File: tb/tb_rgbw_frame_decoder.sv
module tb_rgbw_frame_decoder;
`ifdef RGBW_FRAME_CHECKSUM_EN
  localparam int FLEN = 6;
`else
  localparam int FLEN = 5;
`endif

  logic       clk, reset, cs, rdy;
  logic [7:0] data;
  logic [7:0] red, green, blue, white;
  logic       update, frame_err;

  rgbw_frame_decoder #(.HDR_TAG(4'hA)) dut (
    .clk(clk), .reset(reset), .cs(cs), .rdy(rdy), .data(data),
    .red(red), .green(green), .blue(blue), .white(white),
    .update(update), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the frame is a list of accepted bytes. It is judged once the list is complete.
  logic [7:0] fr[$];
  logic       ign = 1'b0;
  logic [7:0] m_ch [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
  int         exp_upd = 0, exp_err = 0;
  int         upd_seen = 0, err_seen = 0;

  always @(negedge clk) begin
    if (update === 1'b1) upd_seen++;
    if (frame_err === 1'b1) err_seen++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [7:0] h, x;
    logic       ok;
    if (ign) return;
    fr.push_back(b);
    if (fr.size() == 1 && b[7:4] != 4'hA) begin
      exp_err++;
      ign = 1'b1;
      fr.delete();
      return;
    end
    if (fr.size() == FLEN) begin
      h  = fr[0];
      x  = fr[0] ^ fr[1] ^ fr[2] ^ fr[3] ^ fr[4];
      ok = 1'b1;
      if (FLEN == 6) ok = (x == fr[fr.size()-1]);
      if (ok) begin
        for (int ch = 0; ch < 4; ch++)
          if (h[3-ch]) m_ch[ch] = fr[ch+1];
        exp_upd++;
      end else begin
        exp_err++;
      end
      fr.delete();
    end
  endtask

  task automatic model_cs();
    if (fr.size() > 0) exp_err++;
    fr.delete();
    ign = 1'b0;
  endtask

  task automatic check_all(input string tag);
    @(negedge clk); #1;
    check({tag, ".red"},   {24'h0, red},   {24'h0, m_ch[0]});
    check({tag, ".green"}, {24'h0, green}, {24'h0, m_ch[1]});
    check({tag, ".blue"},  {24'h0, blue},  {24'h0, m_ch[2]});
    check({tag, ".white"}, {24'h0, white}, {24'h0, m_ch[3]});
    check({tag, ".upd_cnt"}, upd_seen, exp_upd);
    check({tag, ".err_cnt"}, err_seen, exp_err);
  endtask

  // One byte with rdy held 'hold' cycles; checks the one-cycle output latency.
  task automatic send(input logic [7:0] b, input int hold);
    int pu, pe;
    @(negedge clk);
    rdy = 1'b1; data = b;
    @(posedge clk); #1;
    pu = exp_upd; pe = exp_err;
    model_byte(b);
    check("upd_lat", {31'h0, update},    {31'h0, 1'(exp_upd != pu)});
    check("err_lat", {31'h0, frame_err}, {31'h0, 1'(exp_err != pe)});
    repeat (hold - 1) @(posedge clk);
    @(negedge clk);
    rdy = 1'b0; data = 8'($urandom);
    @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] h, r, g, bb, w, input int hold, input logic bad);
    logic [7:0] f [6];
    f[0] = h; f[1] = r; f[2] = g; f[3] = bb; f[4] = w;
    f[5] = h ^ r ^ g ^ bb ^ w ^ {7'h0, bad};
    for (int i = 0; i < FLEN; i++) send(f[i], hold);
  endtask

  // cs pulse, optionally with a coincident rdy rising edge that must be dropped.
  task automatic cs_pulse(input logic with_byte, input logic [7:0] b);
    int pe;
    @(negedge clk);
    cs = 1'b1;
    if (with_byte) begin rdy = 1'b1; data = b; end
    @(posedge clk); #1;
    pe = exp_err;
    model_cs();
    check("cs_err", {31'h0, frame_err}, {31'h0, 1'(exp_err != pe)});
    @(negedge clk);
    cs = 1'b0; rdy = 1'b0;
    @(posedge clk);
  endtask

  function automatic logic [7:0] bad_hdr();
    logic [7:0] b;
    b = 8'($urandom);
    if (b[7:4] == 4'hA) b[7:4] = 4'h5;
    return b;
  endfunction

  initial begin
    logic [7:0] r, g, bb, w;
    int         k;
    reset = 1'b0; cs = 1'b1; rdy = 1'b0; data = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    check("rst.red", {24'h0, red}, 32'h0);
    check("rst.white", {24'h0, white}, 32'h0);
    check("rst.update", {31'h0, update}, 32'h0);
    check("rst.frame_err", {31'h0, frame_err}, 32'h0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); cs = 1'b0;

    // Basic full-mask frame, rdy held two cycles per byte.
    send_frame(8'hAF, 8'h10, 8'h20, 8'h30, 8'h40, 2, 1'b0);
    check_all("full");
    // Partial mask: only R and W load.
    send_frame(8'hA9, 8'h01, 8'h02, 8'h03, 8'h04, 1, 1'b0);
    check_all("mask9");
    // Bad header: everything ignored until cs returns high.
    send(8'h5F, 1);
    for (int i = 0; i < 4; i++) send(8'($urandom), 1);
    check_all("badhdr");
    cs_pulse(1'b0, 8'h00);
    send_frame(8'hAF, 8'h11, 8'h22, 8'h33, 8'h44, 1, 1'b0);
    check_all("recover");
    // Abort mid-frame, then a full frame from index 0.
    send(8'hAF, 1); send(8'h99, 1); send(8'h98, 1);
    cs_pulse(1'b0, 8'h00);
    check_all("abort");
    send_frame(8'hAE, 8'h51, 8'h52, 8'h53, 8'h54, 3, 1'b0);
    check_all("after_abort");
    // Back-to-back frames under one cs-low period.
    send_frame(8'hAF, 8'h61, 8'h62, 8'h63, 8'h64, 1, 1'b0);
    send_frame(8'hAF, 8'h71, 8'h72, 8'h73, 8'h74, 2, 1'b0);
    check_all("b2b");
    // cs high coincident with rdy rising: header byte dropped.
    cs_pulse(1'b1, 8'hAF);
    send(8'h10, 1);
    check_all("cs_drop");
    cs_pulse(1'b0, 8'h00);
    // Mask 0 still pulses update, colours unchanged.
    send_frame(8'hA0, 8'h81, 8'h82, 8'h83, 8'h84, 1, 1'b0);
    check_all("mask0");
    // Async reset mid-frame.
    send(8'hAF, 1); send(8'h12, 1);
    @(negedge clk); reset = 1'b0; #1;
    check("midrst.red", {24'h0, red}, 32'h0);
    check("midrst.green", {24'h0, green}, 32'h0);
    check("midrst.update", {31'h0, update}, 32'h0);
    fr.delete(); ign = 1'b0;
    for (int i = 0; i < 4; i++) m_ch[i] = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check_all("midrst");
    send_frame(8'hAF, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 1, 1'b0);
    check_all("post_rst");
`ifdef RGBW_FRAME_CHECKSUM_EN
    send_frame(8'hAF, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 1, 1'b1);
    check_all("bad_ck");
`endif

    // Randomized traffic against the model.
    for (int it = 0; it < 60; it++) begin
      r = 8'($urandom); g = 8'($urandom); bb = 8'($urandom); w = 8'($urandom);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5:
          send_frame({4'hA, 4'($urandom)}, r, g, bb, w, $urandom_range(1, 3), 1'b0);
        6: begin
          send(bad_hdr(), 1);
          send(r, 1); send(g, 2);
          cs_pulse(1'b0, 8'h00);
        end
        7: begin
          k = $urandom_range(0, FLEN - 2);
          send({4'hA, 4'($urandom)}, 1);
          for (int i = 0; i < k; i++) send(8'($urandom), $urandom_range(1, 2));
          cs_pulse($urandom_range(0, 1) == 1, 8'($urandom));
        end
        8: cs_pulse(1'b1, 8'($urandom));
        default:
          send_frame({4'hA, 4'($urandom)}, r, g, bb, w, 1, (FLEN == 6));
      endcase
      if (it % 10 == 9) check_all("rand");
    end
    check_all("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
